// File: rtl/dcmps_pkg.sv
// Shared types and constants for the DCM phase-shift responder.
// Optional lock tracking is enabled by defining DCMPS_RESP_LOCK_EN.
package dcmps_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned PHASE_W       = 9;
    localparam int unsigned SUM_W         = PHASE_W + 1;
    localparam int unsigned TIMER_W       = 8;
    localparam int unsigned STATUS_W      = 8;
    localparam int unsigned STATUS_OVF    = 0;
    localparam int unsigned STATUS_UNLOCK = 1;

    // One-tap step on a sign-extended phase so the limit test cannot wrap
    function automatic logic [SUM_W-1:0] step_phase(input logic [PHASE_W-1:0] phase,
                                                    input logic               inc);
        logic [SUM_W-1:0] ext;
        ext = {phase[PHASE_W-1], phase};
        return inc ? ext + SUM_W'(1) : ext - SUM_W'(1);
    endfunction

endpackage

// File: rtl/dcmps_latency_timer.sv
// Loadable down-counter; expire_o is high in the cycle the count reads 1.
// Has no dependence on DCMPS_RESP_LOCK_EN.
module dcmps_latency_timer
    import dcmps_pkg::*;
#(
    parameter int unsigned W = TIMER_W
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] value_i,
    output logic         expire_o
);

    logic [W-1:0] count_q, count_d;
    logic         expire_q, expire_d;

    // Expire is computed from the next count so it can be registered
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
        expire_d = (count_d == W'(1));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q  <= '0;
            expire_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            expire_q <= expire_d;
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/dcm_ps_responder.sv
// Responder model of the DCM_SP variable phase-shift port (PSEN/PSINCDEC/PSDONE/STATUS).
// Define DCMPS_RESP_LOCK_EN to add locked_i gating and status_o[1] unlock reporting.
module dcm_ps_responder
    import dcmps_pkg::*;
#(
    parameter int PS_LATENCY = 12,
    parameter int PS_MAX     = 255,
    parameter int PS_MIN     = -255,
    parameter int PS_INIT    = 0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                psen_i,
    input  logic                psincdec_i,
`ifdef DCMPS_RESP_LOCK_EN
    input  logic                locked_i,
`endif
    output logic                psdone_o,
    output logic [STATUS_W-1:0] status_o,
    output logic [PHASE_W-1:0]  phase_o,
    output logic                busy_o
);

    localparam logic signed [SUM_W-1:0]   MAX_S  = SUM_W'(PS_MAX);
    localparam logic signed [SUM_W-1:0]   MIN_S  = SUM_W'(PS_MIN);
    localparam logic signed [PHASE_W-1:0] INIT_S = PHASE_W'(PS_INIT);
    localparam logic [TIMER_W-1:0]        LOAD_V = TIMER_W'(PS_LATENCY - 1);

    state_t                      state_q, state_d;
    logic                        dir_q, dir_d;
    logic signed [PHASE_W-1:0]   phase_q, phase_d;
    logic                        ovf_q, ovf_d;
    logic                        done_q, done_d;
    logic                        busy_q, busy_d;
    logic                        unlock_q;
    logic                        tmr_load, tmr_clear, tmr_expire;
    logic                        psen_ok, lock_lost, sat;
    logic signed [SUM_W-1:0]     sum_w;

`ifdef DCMPS_RESP_LOCK_EN
    logic unlock_d;
    assign psen_ok   = psen_i & locked_i;
    assign lock_lost = ~locked_i;
    assign unlock_d  = ~locked_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            unlock_q <= 1'b0;
        end else begin
            unlock_q <= unlock_d;
        end
    end
`else
    assign psen_ok   = psen_i;
    assign lock_lost = 1'b0;
    assign unlock_q  = 1'b0;
`endif

    dcmps_latency_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .load_i   (tmr_load),
        .clear_i  (tmr_clear),
        .value_i  (LOAD_V),
        .expire_o (tmr_expire)
    );

    assign sum_w = $signed(step_phase(phase_q, dir_q));
    assign sat   = dir_q ? (sum_w > MAX_S) : (sum_w < MIN_S);

    // Next-state, phase commit and overflow tracking
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        phase_d   = phase_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (psen_ok) begin
                    dir_d    = psincdec_i;
                    tmr_load = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (lock_lost) begin
                    tmr_clear = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else if (tmr_expire) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                    if (sat) begin
                        ovf_d = 1'b1;
                    end else begin
                        phase_d = sum_w[PHASE_W-1:0];
                        ovf_d   = 1'b0;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            phase_q <= INIT_S;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        status_o                = '0;
        status_o[STATUS_OVF]    = ovf_q;
        status_o[STATUS_UNLOCK] = unlock_q;
    end

    assign psdone_o = done_q;
    assign phase_o  = phase_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_dcm_ps_responder.sv
// Scoreboard bench for dcm_ps_responder; lock checks are built when DCMPS_RESP_LOCK_EN is defined.
module tb_dcm_ps_responder;

    localparam int L  = 12;
    localparam int L2 = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       psen, dir, psen2, dir2, lock1;
    logic       done1, busy1, done2, busy2;
    logic [7:0] st1, st2;
    logic [8:0] ph1, ph2;

    always #5 clk = ~clk;

    dcm_ps_responder #(.PS_LATENCY(L)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .psen_i     (psen),
        .psincdec_i (dir),
`ifdef DCMPS_RESP_LOCK_EN
        .locked_i   (lock1),
`endif
        .psdone_o   (done1),
        .status_o   (st1),
        .phase_o    (ph1),
        .busy_o     (busy1)
    );

    dcm_ps_responder #(.PS_LATENCY(L2), .PS_INIT(-255)) dut_min (
        .clk_i      (clk),
        .reset_i    (reset),
        .psen_i     (psen2),
        .psincdec_i (dir2),
`ifdef DCMPS_RESP_LOCK_EN
        .locked_i   (1'b1),
`endif
        .psdone_o   (done2),
        .status_o   (st2),
        .phase_o    (ph2),
        .busy_o     (busy2)
    );

    typedef struct {
        int         cyc;
        logic [8:0] phase;
        logic [7:0] status;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   cyc = 0;
    int   vec = 0;
    int   miss = 0;
    int   done_cnt1 = 0;
    int   mphase = 0;
    logic movf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(got), $signed(exp));
        end
    endtask

    // Monitor for the main instance
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done1 === 1'b1) begin
            done_cnt1++;
            vec++;
            if (q1.size() == 0) begin
                miss++;
                $display("FAIL dut_unexpected_psdone: cycle %0d phase %0d status %h, none expected",
                         cyc, $signed(ph1), st1);
            end else begin
                e = q1.pop_front();
                if (cyc != e.cyc || ph1 !== e.phase || st1 !== e.status) begin
                    miss++;
                    $display("FAIL dut_psdone: got cycle %0d phase %0d status %h, expected cycle %0d phase %0d status %h",
                             cyc, $signed(ph1), st1, e.cyc, $signed(e.phase), e.status);
                end
            end
        end
    end

    // Monitor for the PS_INIT=-255 instance
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done2 === 1'b1) begin
            vec++;
            if (q2.size() == 0) begin
                miss++;
                $display("FAIL dut_min_unexpected_psdone: cycle %0d phase %0d", cyc, $signed(ph2));
            end else begin
                e = q2.pop_front();
                if (cyc != e.cyc || ph2 !== e.phase || st2 !== e.status) begin
                    miss++;
                    $display("FAIL dut_min_psdone: got cycle %0d phase %0d status %h, expected cycle %0d phase %0d status %h",
                             cyc, $signed(ph2), st2, e.cyc, $signed(e.phase), e.status);
                end
            end
        end
    end

    // Reference phase/overflow model for the main instance
    task automatic push1(input logic inc, input int at);
        if (inc) begin
            if (mphase == 255) movf = 1'b1;
            else begin mphase++; movf = 1'b0; end
        end else begin
            if (mphase == -255) movf = 1'b1;
            else begin mphase--; movf = 1'b0; end
        end
        q1.push_back('{at, 9'(mphase), {7'b0, movf}});
    endtask

    task automatic issue(input logic inc, input bit expect_done);
        @(negedge clk);
        psen = 1'b1;
        dir  = inc;
        if (expect_done) push1(inc, cyc + L);
        @(negedge clk);
        psen = 1'b0;
        dir  = ~inc;
    endtask

    task automatic run_req(input logic inc);
        issue(inc, 1'b1);
        repeat (L - 1) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, %0d vectors so far", vec);
        $fatal(1, "timeout");
    end

    initial begin
        int n, d0;
        reset = 1'b1; psen = 1'b0; dir = 1'b0; psen2 = 1'b0; dir2 = 1'b0; lock1 = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_psdone", 32'(done1), 0);
        check("reset_status", 32'(st1), 0);
        check("reset_phase", $signed(ph1), 0);
        check("reset_busy", 32'(busy1), 0);
        check("reset_phase_min", $signed(ph2), -255);

        // Single increment; DONE cycle still shows busy
        run_req(1'b1);
        check("single_inc_phase", $signed(ph1), 1);
        check("single_inc_busy_in_done", 32'(busy1), 1);
        @(negedge clk);
        check("single_inc_busy_after", 32'(busy1), 0);

        // Reset at cycle 5 of a request
        issue(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mphase = 0; movf = 1'b0;
        check("midreset_busy", 32'(busy1), 0);
        check("midreset_psdone", 32'(done1), 0);
        check("midreset_phase", $signed(ph1), 0);
        repeat (L + 4) @(negedge clk);

        // Walk to the upper limit, saturate, then step back off it
        for (int i = 0; i < 255; i++) run_req(1'b1);
        check("upper_phase", $signed(ph1), 255);
        check("upper_status", 32'(st1), 0);
        run_req(1'b1);
        check("sat_phase", $signed(ph1), 255);
        check("sat_status", 32'(st1), 1);
        run_req(1'b0);
        check("off_limit_phase", $signed(ph1), 254);
        check("off_limit_status", 32'(st1), 0);

        // psen held high for 20 cycles: accepts at n and n+L+1 only
        @(negedge clk);
        d0 = done_cnt1;
        psen = 1'b1; dir = 1'b1;
        n = cyc + 1;
        push1(1'b1, n + L - 1);
        push1(1'b1, n + 2 * L);
        repeat (20) @(negedge clk);
        psen = 1'b0;
        repeat (L + 2) @(negedge clk);
        check("held_psdone_count", 32'(done_cnt1 - d0), 2);
        check("held_status", 32'(st1), 1);

        // Strobe during the DONE cycle is dropped
        issue(1'b0, 1'b1);
        repeat (L - 1) @(negedge clk);
        psen = 1'b1; dir = 1'b1;
        @(negedge clk);
        psen = 1'b0;
        repeat (L + 3) @(negedge clk);
        check("overlap_phase", $signed(ph1), 254);
        check("overlap_busy", 32'(busy1), 0);

        // Decrement at the lower limit on the PS_INIT=-255 instance
        @(negedge clk);
        psen2 = 1'b1; dir2 = 1'b0;
        q2.push_back('{cyc + L2, 9'h101, 8'h01});
        @(negedge clk);
        psen2 = 1'b0;
        repeat (L2 + 1) @(negedge clk);
        check("min_sat_phase", $signed(ph2), -255);
        psen2 = 1'b1; dir2 = 1'b1;
        q2.push_back('{cyc + L2, 9'h102, 8'h00});
        @(negedge clk);
        psen2 = 1'b0;
        repeat (L2 + 1) @(negedge clk);
        check("min_off_limit_status", 32'(st2), 0);

`ifdef DCMPS_RESP_LOCK_EN
        lock1 = 1'b0;
        repeat (2) @(negedge clk);
        check("unlock_status", 32'(st1[1]), 1);
        issue(1'b1, 1'b0);
        check("unlock_psen_ignored_busy", 32'(busy1), 0);
        repeat (L + 2) @(negedge clk);
        lock1 = 1'b1;
        @(negedge clk);
        check("relock_status", 32'(st1[1]), 0);
        issue(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        lock1 = 1'b0;
        repeat (L + 2) @(negedge clk);
        check("lock_abort_phase", $signed(ph1), 254);
        check("lock_abort_busy", 32'(busy1), 0);
        lock1 = 1'b1;
        repeat (2) @(negedge clk);
`endif

        check("dut_pending_expectations", 32'(q1.size()), 0);
        check("dut_min_pending_expectations", 32'(q2.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
